// File: rtl/key_input_sequencer.sv
// Five-key front end: synchronise and debounce raw keys, arbitrate by fixed priority,
// strobe one encoder line, capture its code and hand it downstream on valid/ready.
module key_input_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] KEY_RAW,
  output logic [4:0] SEL_K,
  input  logic [7:0] CODE_IN,
  output logic [7:0] CODE_OUT,
  output logic       VALID,
  input  logic       READY,
  output logic [2:0] KEY_ID,
  output logic       BUSY,
  output logic       DROP
);

  localparam int NK = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // K1 (bit 0) has the highest priority.
  function automatic logic [4:0] lowest_set(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

  function automatic logic [2:0] key_index(input logic [4:0] oh);
    case (oh)
      5'b00001: return 3'd1;
      5'b00010: return 3'd2;
      5'b00100: return 3'd3;
      5'b01000: return 3'd4;
      5'b10000: return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  logic [4:0]       deb_p2;
  logic [4:0]       deb_nxt;
  logic [4:0]       rise_p3;
  logic [CNT_W-1:0] cnt     [NK];
  logic [CNT_W-1:0] cnt_nxt [NK];

  state_t     state, state_nxt;
  logic [4:0] sel_nxt;
  logic [7:0] code_nxt;
  logic       valid_nxt;
  logic [2:0] id_nxt;
  logic       drop_nxt;
  logic       multi_rise;

  // Stage p0/p1: two-flop synchroniser on the asynchronous key lines
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= KEY_RAW;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-key debounce; a level change is accepted after DEB_CYCLES differing samples
  always_comb begin
    deb_nxt = deb_p2;
    for (int i = 0; i < NK; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p1[i] != deb_p2[i]) begin
        if (cnt[i] == CNT_MAX) deb_nxt[i] = ~deb_p2[i];
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_p2  <= '0;
      rise_p3 <= '0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
    end else begin
      deb_p2  <= deb_nxt;
      rise_p3 <= deb_nxt & ~deb_p2;
      for (int i = 0; i < NK; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Stage p3: press events feed the sequencing FSM
  assign multi_rise = (rise_p3 & (rise_p3 - 5'd1)) != 5'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = SEL_K;
    code_nxt  = CODE_OUT;
    valid_nxt = VALID;
    id_nxt    = KEY_ID;
    drop_nxt  = multi_rise || ((rise_p3 != 5'd0) && (state != IDLE));
    case (state)
      IDLE: begin
        if (rise_p3 != 5'd0) begin
          sel_nxt   = lowest_set(rise_p3);
          state_nxt = DRIVE;
        end
      end
      DRIVE: state_nxt = CAPTURE;
      CAPTURE: begin
        code_nxt  = CODE_IN;
        id_nxt    = key_index(SEL_K);
        valid_nxt = 1'b1;
        sel_nxt   = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (READY) begin
          valid_nxt = 1'b0;
          id_nxt    = '0;
          state_nxt = (deb_p2 == 5'd0) ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (deb_p2 == 5'd0) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
        valid_nxt = 1'b0;
        id_nxt    = '0;
      end
    endcase
  end

  // Registered outputs; reset clears everything so an aborted sequence leaves no code behind
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL_K    <= '0;
      CODE_OUT <= '0;
      VALID    <= 1'b0;
      KEY_ID   <= '0;
      DROP     <= 1'b0;
    end else begin
      SEL_K    <= sel_nxt;
      CODE_OUT <= code_nxt;
      VALID    <= valid_nxt;
      KEY_ID   <= id_nxt;
      DROP     <= drop_nxt;
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_key_input_sequencer.sv
// Directed bench for key_input_sequencer with a behavioural 5-key encoder model.
module tb_key_input_sequencer;

  logic       CLK;
  logic       RST;
  logic [4:0] KEY_RAW;
  logic [4:0] SEL_K;
  logic [7:0] CODE_IN;
  logic [7:0] CODE_OUT;
  logic       VALID;
  logic       READY;
  logic [2:0] KEY_ID;
  logic       BUSY;
  logic       DROP;

  int checks = 0;
  int errors = 0;

  int n_acc = 0;
  int n_drop = 0;
  int n_bad_sel = 0;

  key_input_sequencer #(.DEB_CYCLES(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .KEY_RAW(KEY_RAW), .SEL_K(SEL_K), .CODE_IN(CODE_IN),
    .CODE_OUT(CODE_OUT), .VALID(VALID), .READY(READY), .KEY_ID(KEY_ID),
    .BUSY(BUSY), .DROP(DROP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Encoder: K1..K5 -> 72 03 BB E3 37
  always_comb begin
    case (SEL_K)
      5'b00001: CODE_IN = 8'h72;
      5'b00010: CODE_IN = 8'h03;
      5'b00100: CODE_IN = 8'hBB;
      5'b01000: CODE_IN = 8'hE3;
      5'b10000: CODE_IN = 8'h37;
      default:  CODE_IN = 8'h00;
    endcase
  end

  always @(posedge CLK) begin
    if (VALID && READY) n_acc++;
    if (DROP) n_drop++;
    if ((SEL_K & (SEL_K - 5'd1)) != 5'd0) n_bad_sel++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step(1);
      if (VALID) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; KEY_RAW = '0; READY = 1'b0;
    step(2);
    checks++;
    if ({SEL_K, CODE_OUT, VALID, KEY_ID, BUSY, DROP} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%b code=%h valid=%b id=%0d busy=%b drop=%b, want all 0",
               SEL_K, CODE_OUT, VALID, KEY_ID, BUSY, DROP);
    end
    #3 RST = 1'b0;
    step(2);
  endtask

  task automatic test_k1_clean;
    int acc0, drop0;
    acc0 = n_acc; drop0 = n_drop;
    READY = 1'b1; KEY_RAW = 5'b00001;
    step(6);
    checks++;
    if (SEL_K !== 5'd0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL k1_pre_event: sel=%b busy=%b, want 00000 0", SEL_K, BUSY);
    end
    step(1);
    checks++;
    if (SEL_K !== 5'b00001 || BUSY !== 1'b1) begin
      errors++; $display("FAIL k1_drive: sel=%b busy=%b, want 00001 1", SEL_K, BUSY);
    end
    step(1);
    checks++;
    if (SEL_K !== 5'b00001 || VALID !== 1'b0) begin
      errors++; $display("FAIL k1_capture: sel=%b valid=%b, want 00001 0", SEL_K, VALID);
    end
    step(1);
    checks++;
    if (VALID !== 1'b1 || CODE_OUT !== 8'h72 || KEY_ID !== 3'd1 || SEL_K !== 5'd0) begin
      errors++;
      $display("FAIL k1_valid: valid=%b code=%h id=%0d sel=%b, want 1 72 1 00000", VALID, CODE_OUT, KEY_ID, SEL_K);
    end
    step(1);
    checks++;
    if (VALID !== 1'b0 || KEY_ID !== 3'd0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL k1_after_accept: valid=%b id=%0d busy=%b, want 0 0 1", VALID, KEY_ID, BUSY);
    end
    step(10);
    KEY_RAW = '0;
    step(12);
    checks++;
    if (BUSY !== 1'b0 || (n_acc - acc0) != 1 || (n_drop - drop0) != 0) begin
      errors++;
      $display("FAIL k1_one_code: busy=%b codes=%0d drops=%0d, want 0 1 0", BUSY, n_acc - acc0, n_drop - drop0);
    end
  endtask

  task automatic test_k3_backpressure;
    bit ok;
    int acc0;
    acc0 = n_acc;
    READY = 1'b0; KEY_RAW = 5'b00100;
    wait_valid(20, ok);
    checks++;
    if (!ok || CODE_OUT !== 8'hBB || KEY_ID !== 3'd3) begin
      errors++; $display("FAIL k3_valid: seen=%b code=%h id=%0d, want 1 BB 3", ok, CODE_OUT, KEY_ID);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (VALID !== 1'b1 || CODE_OUT !== 8'hBB || KEY_ID !== 3'd3) begin
        errors++;
        $display("FAIL k3_hold_%0d: valid=%b code=%h id=%0d, want 1 BB 3", i, VALID, CODE_OUT, KEY_ID);
      end
    end
    READY = 1'b1;
    step(1);
    checks++;
    if (VALID !== 1'b0 || KEY_ID !== 3'd0) begin
      errors++; $display("FAIL k3_accept: valid=%b id=%0d, want 0 0", VALID, KEY_ID);
    end
    KEY_RAW = '0;
    step(12);
    checks++;
    if (BUSY !== 1'b0 || (n_acc - acc0) != 1) begin
      errors++; $display("FAIL k3_one_code: busy=%b codes=%0d, want 0 1", BUSY, n_acc - acc0);
    end
  endtask

  task automatic test_simultaneous;
    int acc0, drop0;
    acc0 = n_acc; drop0 = n_drop;
    READY = 1'b1; KEY_RAW = 5'b10010;
    step(7);
    checks++;
    if (DROP !== 1'b1 || SEL_K !== 5'b00010) begin
      errors++; $display("FAIL simul_drive: drop=%b sel=%b, want 1 00010", DROP, SEL_K);
    end
    step(1);
    checks++;
    if (DROP !== 1'b0) begin
      errors++; $display("FAIL simul_drop_width: drop=%b, want 0", DROP);
    end
    step(1);
    checks++;
    if (VALID !== 1'b1 || CODE_OUT !== 8'h03 || KEY_ID !== 3'd2) begin
      errors++; $display("FAIL simul_valid: valid=%b code=%h id=%0d, want 1 03 2", VALID, CODE_OUT, KEY_ID);
    end
    step(8);
    KEY_RAW = '0;
    step(12);
    checks++;
    if (BUSY !== 1'b0 || (n_acc - acc0) != 1 || (n_drop - drop0) != 1) begin
      errors++;
      $display("FAIL simul_counts: busy=%b codes=%0d drops=%0d, want 0 1 1", BUSY, n_acc - acc0, n_drop - drop0);
    end
  endtask

  task automatic test_bounce;
    bit ok;
    int acc0, drop0;
    acc0 = n_acc; drop0 = n_drop;
    READY = 1'b1;
    repeat (3) begin
      KEY_RAW = 5'b01000; step(2);
      KEY_RAW = 5'b00000; step(2);
    end
    step(4);
    checks++;
    if (BUSY !== 1'b0 || (n_acc - acc0) != 0) begin
      errors++; $display("FAIL bounce_filtered: busy=%b codes=%0d, want 0 0", BUSY, n_acc - acc0);
    end
    KEY_RAW = 5'b01000;
    wait_valid(20, ok);
    checks++;
    if (!ok || CODE_OUT !== 8'hE3 || KEY_ID !== 3'd4) begin
      errors++; $display("FAIL bounce_valid: seen=%b code=%h id=%0d, want 1 E3 4", ok, CODE_OUT, KEY_ID);
    end
    step(6);
    KEY_RAW = '0;
    step(12);
    checks++;
    if (BUSY !== 1'b0 || (n_acc - acc0) != 1 || (n_drop - drop0) != 0) begin
      errors++;
      $display("FAIL bounce_counts: busy=%b codes=%0d drops=%0d, want 0 1 0", BUSY, n_acc - acc0, n_drop - drop0);
    end
  endtask

  task automatic test_press_in_release;
    bit ok;
    int acc0, drop0;
    acc0 = n_acc; drop0 = n_drop;
    READY = 1'b1; KEY_RAW = 5'b10000;
    wait_valid(20, ok);
    checks++;
    if (!ok || CODE_OUT !== 8'h37 || KEY_ID !== 3'd5) begin
      errors++; $display("FAIL k5_valid: seen=%b code=%h id=%0d, want 1 37 5", ok, CODE_OUT, KEY_ID);
    end
    step(1);
    KEY_RAW = 5'b10001;
    step(8);
    checks++;
    if (BUSY !== 1'b1 || (n_drop - drop0) != 1 || (n_acc - acc0) != 1) begin
      errors++;
      $display("FAIL k1_dropped: busy=%b drops=%0d codes=%0d, want 1 1 1", BUSY, n_drop - drop0, n_acc - acc0);
    end
    KEY_RAW = '0;
    step(12);
    checks++;
    if (BUSY !== 1'b0 || (n_acc - acc0) != 1) begin
      errors++; $display("FAIL release_idle: busy=%b codes=%0d, want 0 1", BUSY, n_acc - acc0);
    end
    KEY_RAW = 5'b00001;
    wait_valid(20, ok);
    checks++;
    if (!ok || CODE_OUT !== 8'h72 || KEY_ID !== 3'd1) begin
      errors++; $display("FAIL k1_repress: seen=%b code=%h id=%0d, want 1 72 1", ok, CODE_OUT, KEY_ID);
    end
    step(4);
    KEY_RAW = '0;
    step(12);
  endtask

  task automatic test_reset_in_drive;
    int acc0;
    acc0 = n_acc;
    READY = 1'b1; KEY_RAW = 5'b00100;
    step(7);
    checks++;
    if (SEL_K !== 5'b00100) begin
      errors++; $display("FAIL rst_pre_drive: sel=%b, want 00100", SEL_K);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (SEL_K !== 5'd0 || VALID !== 1'b0 || KEY_ID !== 3'd0 || BUSY !== 1'b0 || CODE_OUT !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: sel=%b valid=%b id=%0d busy=%b code=%h, want all 0",
               SEL_K, VALID, KEY_ID, BUSY, CODE_OUT);
    end
    KEY_RAW = '0;
    #2 RST = 1'b0;
    step(15);
    checks++;
    if (VALID !== 1'b0 || BUSY !== 1'b0 || (n_acc - acc0) != 0) begin
      errors++; $display("FAIL rst_no_code: valid=%b busy=%b codes=%0d, want 0 0 0", VALID, BUSY, n_acc - acc0);
    end
  endtask

  task automatic test_sel_onehot;
    checks++;
    if (n_bad_sel != 0) begin
      errors++; $display("FAIL sel_onehot: non-onehot cycles=%0d, want 0", n_bad_sel);
    end
  endtask

  initial begin
    test_reset;
    test_k1_clean;
    test_k3_backpressure;
    test_simultaneous;
    test_bounce;
    test_press_in_release;
    test_reset_in_drive;
    test_sel_onehot;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish, want finish");
    $fatal(1);
  end

endmodule
